// File: rtl/mult_div_unit.sv
// Multi-cycle integer multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per cycle, with sign
// correction applied once in a final FIX cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; direct hi/lo writes accepted here
// RUN   | N iterations of shift-add or restoring divide
// FIX   | sign correction, hi/lo written, done pulsed
// ZDIV  | divide by zero: hi = dividend, lo = all ones, flag raised

module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         hi_write,
    input  logic         lo_write,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_ZDIV = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [N-1:0]       mcand_q, mcand_d;   // multiplicand, or divisor
    logic [2*N-1:0]     work_q, work_d;     // accumulator; low half is quotient for divides
    logic [N-1:0]       rem_q, rem_d;       // remainder always < divisor, so N bits hold it
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       hi_q, hi_d;
    logic [N-1:0]       lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               op_signed;
    logic               op_div;
    logic               a_neg_in;
    logic               b_neg_in;
    logic [N-1:0]       a_abs;
    logic [N-1:0]       b_abs;
    logic               div_zero_in;

    logic [N:0]         mul_sum;
    logic [2*N-1:0]     mul_next;
    logic [N:0]         div_shift;
    logic [N:0]         div_diff;
    logic               div_ok;
    logic [N-1:0]       rem_next;
    logic [N-1:0]       quo_next;

    logic               res_neg;
    logic [2*N-1:0]     prod_fix;
    logic [N-1:0]       quo_fix;
    logic [N-1:0]       rem_fix;
    logic               last_iter;

    // Operand conditioning at the start edge: magnitudes and signs for signed ops.
    always_comb begin
        op_signed   = op[0];
        op_div      = op[1];
        a_neg_in    = op_signed & inA[N-1];
        b_neg_in    = op_signed & inB[N-1];
        a_abs       = a_neg_in ? -inA : inA;
        b_abs       = b_neg_in ? -inB : inB;
        div_zero_in = op_div && (inB == '0);
    end

    // One iteration of each algorithm plus the final sign correction.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*N-1:N]} + (work_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, work_q[N-1:1]};

        // The partial remainder needs N+1 bits for the trial subtraction.
        div_shift = {rem_q, work_q[N-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        div_ok    = ~div_diff[N];
        rem_next  = div_ok ? div_diff[N-1:0] : div_shift[N-1:0];
        quo_next  = {work_q[N-2:0], div_ok};

        res_neg   = neg_a_q ^ neg_b_q;
        prod_fix  = res_neg ? -work_q : work_q;
        quo_fix   = res_neg ? -work_q[N-1:0] : work_q[N-1:0];
        // Remainder follows the dividend's sign (truncating division).
        rem_fix   = neg_a_q ? -rem_q : rem_q;

        last_iter = (cnt_q == CNT_W'(1));
    end

    // Next-state and register update logic for the sequencer.
    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        mcand_d  = mcand_q;
        work_d   = work_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d   = 1'b1;
                    dbz_d    = 1'b0;
                    is_div_d = op_div;
                    neg_a_d  = a_neg_in;
                    neg_b_d  = b_neg_in;
                    cnt_d    = CNT_W'(N);
                    rem_d    = '0;
                    if (div_zero_in) begin
                        // Keep the raw dividend so hi reports it unmodified.
                        state_d = S_ZDIV;
                        mcand_d = '0;
                        work_d  = {{N{1'b0}}, inA};
                    end else begin
                        state_d = S_RUN;
                        mcand_d = op_div ? b_abs : a_abs;
                        work_d  = {{N{1'b0}}, (op_div ? a_abs : b_abs)};
                    end
                end else begin
                    if (hi_write) begin
                        hi_d = wdata;
                    end
                    if (lo_write) begin
                        lo_d = wdata;
                    end
                end
            end

            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div_q) begin
                    rem_d  = rem_next;
                    work_d = {work_q[2*N-1:N], quo_next};
                end else begin
                    work_d = mul_next;
                end
                if (last_iter) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*N-1:N];
                    lo_d = prod_fix[N-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            S_ZDIV: begin
                hi_d    = work_q[N-1:0];
                lo_d    = '1;
                dbz_d   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            mcand_q  <= '0;
            work_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            mcand_q  <= mcand_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: stimulus pushes expected results into a
// queue, a monitor pops and compares on every done pulse.

module tb_mult_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    int cycle_cnt = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mult_div_unit #(.N(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .inA         (inA),
        .inB         (inB),
        .hi_write    (hi_write),
        .lo_write    (lo_write),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cycle_cnt);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_hi"},  64'(hi), 64'(mon_e.hi));
                chk({mon_e.name, "_lo"},  64'(lo), 64'(mon_e.lo));
                chk({mon_e.name, "_dbz"}, 64'(div_by_zero), 64'(mon_e.dbz));
                chk({mon_e.name, "_latency"}, 64'(cycle_cnt - mon_e.start_cyc), 64'(mon_e.lat));
                chk({mon_e.name, "_busy_at_done"}, 64'(busy), 64'd0);
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edbz, input int elat,
                         input bit push, input bit with_hw);
        exp_t e;
        @(negedge clock);
        op    = o;
        inA   = a;
        inB   = b;
        start = 1'b1;
        if (with_hw) begin
            hi_write = 1'b1;
            wdata    = 32'hDEADBEEF;
        end
        @(posedge clock);
        #1;
        start    = 1'b0;
        hi_write = 1'b0;
        // Scramble operands to prove they were latched at the start edge.
        inA = ~a;
        inB = ~b;
        op  = ~o;
        if (push) begin
            e.name      = name;
            e.hi        = ehi;
            e.lo        = elo;
            e.dbz       = edbz;
            e.lat       = elat;
            e.start_cyc = cycle_cnt;
            sb.push_back(e);
        end
        chk({name, "_busy_after_start"}, 64'(busy), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_idle_timeout"}, 64'(ok), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cycle_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        op       = 2'd0;
        inA      = '0;
        inB      = '0;
        hi_write = 1'b0;
        lo_write = 1'b0;
        wdata    = '0;
        repeat (3) @(negedge clock);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dbz",  64'(div_by_zero), 64'd0);
        chk("reset_hi",   64'(hi), 64'd0);
        chk("reset_lo",   64'(lo), 64'd0);
        reset = 1'b1;

        issue("multu_max", 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1, 0);
        wait_idle("multu_max");
        issue("mult_neg3x5", 2'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 1, 0);
        wait_idle("mult_neg3x5");
        issue("mult_neg2xneg3", 2'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0, 32'd6, 1'b0, 33, 1, 0);
        wait_idle("mult_neg2xneg3");
        issue("div_neg7by2", 2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1, 0);
        wait_idle("div_neg7by2");
        issue("div_7byneg2", 2'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33, 1, 0);
        wait_idle("div_7byneg2");
        issue("divu_7by2", 2'd2, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 33, 1, 0);
        wait_idle("divu_7by2");
        issue("div_overflow", 2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, 1, 0);
        wait_idle("div_overflow");

        issue("divu_zero", 2'd2, 32'h00001234, 32'h0, 32'h00001234, 32'hFFFFFFFF, 1'b1, 1, 1, 0);
        @(posedge clock);
        #1;
        chk("divu_zero_busy_one_cycle", 64'(busy), 64'd0);
        wait_idle("divu_zero");
        chk("dbz_held", 64'(div_by_zero), 64'd1);

        issue("multu_3x4", 2'd0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33, 1, 0);
        chk("dbz_cleared_on_start", 64'(div_by_zero), 64'd0);
        wait_idle("multu_3x4");

        issue("div_neg5_zero", 2'd3, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1, 1, 0);
        wait_idle("div_neg5_zero");

        // Start and hi_write during busy must both be ignored.
        issue("multu_6x7_busy", 2'd0, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, 33, 1, 0);
        repeat (3) @(negedge clock);
        start    = 1'b1;
        op       = 2'd3;
        inA      = 32'd100;
        inB      = 32'd0;
        hi_write = 1'b1;
        lo_write = 1'b1;
        wdata    = 32'h00000055;
        @(posedge clock);
        #1;
        start    = 1'b0;
        hi_write = 1'b0;
        lo_write = 1'b0;
        chk("busy_hi_write_dropped", 64'(hi), 64'hFFFFFFFB);
        chk("busy_lo_write_dropped", 64'(lo), 64'hFFFFFFFF);
        repeat (5) @(negedge clock);
        start = 1'b1;
        op    = 2'd0;
        inA   = 32'd1;
        inB   = 32'd1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_idle("multu_6x7_busy");

        @(negedge clock);
        hi_write = 1'b1;
        wdata    = 32'hA5A5A5A5;
        @(posedge clock);
        #1;
        hi_write = 1'b0;
        chk("mthi_hi", 64'(hi), 64'hA5A5A5A5);
        chk("mthi_lo_unchanged", 64'(lo), 64'd42);

        @(negedge clock);
        hi_write = 1'b1;
        lo_write = 1'b1;
        wdata    = 32'h13579BDF;
        @(posedge clock);
        #1;
        hi_write = 1'b0;
        lo_write = 1'b0;
        chk("both_write_hi", 64'(hi), 64'h13579BDF);
        chk("both_write_lo", 64'(lo), 64'h13579BDF);

        issue("start_beats_mthi", 2'd0, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 33, 1, 1);
        chk("start_beats_mthi_hi_held", 64'(hi), 64'h13579BDF);
        wait_idle("start_beats_mthi");

        // Asynchronous reset in the middle of a signed multiply.
        issue("rst_mult", 2'd1, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, 1'b0, 33, 0, 0);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        chk("async_rst_hi",   64'(hi), 64'd0);
        chk("async_rst_lo",   64'(lo), 64'd0);
        chk("async_rst_dbz",  64'(div_by_zero), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        issue("multu_3x4_after_rst", 2'd0, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33, 1, 0);
        wait_idle("multu_3x4_after_rst");

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
